// File: rtl/hex_share_arbiter.sv
// Three requesters share one 7-segment display: round-robin grant, fixed hold period,
// blank gap, and a one-cycle ack to the requester whose period ended.
module hex_share_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [3:0] code0,
  input  logic [3:0] code1,
  input  logic [3:0] code2,
  output logic [6:0] hex_out,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic       busy
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);
  localparam logic [6:0]      Blank    = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      last_q;
  logic [3:0]      digit_q;

  // Active-low segments, bit6=g .. bit0=a.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Priority order rotates so the search begins just after the previous winner.
  logic [1:0] pri0, pri1, pri2;
  logic [1:0] win_idx;
  logic       win_valid;
  logic [3:0] win_code;

  always_comb begin
    pri0 = 2'd0;
    pri1 = 2'd1;
    pri2 = 2'd2;
    unique case (last_q)
      2'd0: begin
        pri0 = 2'd1;
        pri1 = 2'd2;
        pri2 = 2'd0;
      end
      2'd1: begin
        pri0 = 2'd2;
        pri1 = 2'd0;
        pri2 = 2'd1;
      end
      default: begin
        pri0 = 2'd0;
        pri1 = 2'd1;
        pri2 = 2'd2;
      end
    endcase
    win_valid = |req;
    if (req[pri0]) begin
      win_idx = pri0;
    end else if (req[pri1]) begin
      win_idx = pri1;
    end else begin
      win_idx = pri2;
    end
  end

  always_comb begin
    unique case (win_idx)
      2'd0:    win_code = code0;
      2'd1:    win_code = code1;
      default: win_code = code2;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      digit_q <= '0;
      hex_out <= Blank;
      gnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q <= StShow;
            digit_q <= win_code;
            hex_out <= seg7(win_code);
            gnt     <= 3'b001 << win_idx;
            cnt_q   <= HoldLoad;
            last_q  <= win_idx;
            busy    <= 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == '0) begin
            ack     <= gnt;
            gnt     <= '0;
            hex_out <= Blank;
            cnt_q   <= GapLoad;
            state_q <= StGap;
          end else begin
            hex_out <= seg7(digit_q);
            cnt_q   <= cnt_q - CntW'(1);
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          hex_out <= Blank;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_share_arbiter.sv
// Scoreboard bench for hex_share_arbiter with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_hex_share_arbiter;

  localparam int Hold = 4;
  localparam int Gap  = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] req;
  logic [3:0] code0, code1, code2;
  logic [6:0] hex_out;
  logic [2:0] gnt;
  logic [2:0] ack;
  logic       busy;

  hex_share_arbiter #(
    .HOLD_CYCLES(Hold),
    .GAP_CYCLES (Gap)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .req     (req),
    .code0   (code0),
    .code1   (code1),
    .code2   (code2),
    .hex_out (hex_out),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0] g;
    logic [6:0] h;
    bit         aborted;
    bit         gap_chk;
    int         hold;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  logic [6:0] seg_tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [6:0] h, input bit ab, input bit gc,
                      input int hold);
    exp_t e;
    e.g = g;
    e.h = h;
    e.aborted = ab;
    e.gap_chk = gc;
    e.hold = hold;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever a new grant appears, then tracks its period.
  initial begin
    exp_t       cur;
    logic [2:0] prev_gnt;
    int         hold_cnt;
    int         blank_cnt;
    bit         after_normal;
    cur.g = '0; cur.h = '1; cur.aborted = 1'b0; cur.gap_chk = 1'b0; cur.hold = Hold;
    prev_gnt = '0;
    hold_cnt = 0;
    blank_cnt = 100;
    after_normal = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (gnt != 3'b000) begin
          check("busy_show", 32'(busy), 32'd1);
          check("ack_in_show", 32'(ack), 32'd0);
          if (prev_gnt == 3'b000) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_grant: got gnt %0h want none at %0t", gnt, $time);
              cur.g = gnt; cur.h = hex_out; cur.aborted = 1'b0; cur.gap_chk = 1'b0;
              cur.hold = Hold;
            end else begin
              cur = exp_q.pop_front();
            end
            check("grant", 32'(gnt), 32'(cur.g));
            check("hex_show", 32'(hex_out), 32'(cur.h));
            if (cur.gap_chk) check("gap_len", 32'(blank_cnt), 32'(Gap + 1));
            hold_cnt = 1;
          end else begin
            hold_cnt++;
            check("grant_stable", 32'(gnt), 32'(prev_gnt));
            check("hex_stable", 32'(hex_out), 32'(cur.h));
          end
        end else begin
          check("hex_blank", 32'(hex_out), 32'h7f);
          if (prev_gnt != 3'b000) begin
            blank_cnt = 1;
            check("hold_len", 32'(hold_cnt), 32'(cur.hold));
            if (cur.aborted) begin
              check("no_ack_abort", 32'(ack), 32'd0);
              after_normal = 1'b0;
            end else begin
              check("ack_pulse", 32'(ack), 32'(cur.g));
              after_normal = 1'b1;
            end
          end else begin
            if (blank_cnt < 1000) blank_cnt++;
            check("ack_idle", 32'(ack), 32'd0);
          end
          check("busy_blank", 32'(busy), 32'(after_normal && blank_cnt <= Gap));
        end
        prev_gnt = gnt;
      end
    end
  end

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
    seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;

    resetn = 1'b0;
    req = 3'b000;
    code0 = 4'h0; code1 = 4'h0; code2 = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_hex", 32'(hex_out), 32'h7f);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Single request from requester 0 showing 'A'.
    push(3'b001, 7'b0001000, 1'b0, 1'b0, Hold);
    req = 3'b001;
    code0 = 4'hA;
    @(negedge clk);
    req = 3'b000;
    repeat (10) @(negedge clk);

    // Reset, then all three request continuously: 0,1,2,0 in order.
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    code0 = 4'h1; code1 = 4'h2; code2 = 4'h3;
    push(3'b001, 7'b1111001, 1'b0, 1'b0, Hold);
    push(3'b010, 7'b0100100, 1'b0, 1'b1, Hold);
    push(3'b100, 7'b0110000, 1'b0, 1'b1, Hold);
    push(3'b001, 7'b1111001, 1'b0, 1'b1, Hold);
    req = 3'b111;
    repeat (22) @(negedge clk);
    req = 3'b000;
    repeat (10) @(negedge clk);

    // Code and req change mid-period must not disturb the display or the ack.
    push(3'b001, 7'b0010010, 1'b0, 1'b0, Hold);
    req = 3'b001;
    code0 = 4'h5;
    @(negedge clk);
    code0 = 4'h8;
    req = 3'b000;
    repeat (10) @(negedge clk);

    // Reset at SHOW cycle 2 aborts without ack; requester 1 then wins from req=110.
    push(3'b001, 7'b1000000, 1'b1, 1'b0, 2);
    code0 = 4'h0;
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    code1 = 4'hC;
    code2 = 4'h7;
    push(3'b010, 7'b1000110, 1'b0, 1'b0, Hold);
    req = 3'b110;
    @(negedge clk);
    req = 3'b000;
    repeat (10) @(negedge clk);

    // Full decoder sweep through requester 2.
    for (int i = 0; i < 16; i++) begin
      push(3'b100, seg_tbl[i], 1'b0, 1'b0, Hold);
      code2 = 4'(i);
      req = 3'b100;
      @(negedge clk);
      req = 3'b000;
      repeat (8) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
